// File: rtl/ula_param.sv
// rtl/ula_param.sv - sequential NxN matrix ALU, one element or one MAC per clock
// ULA_SAT_EN: saturate out-of-range elements instead of wrapping.
module ula_param #(
    parameter int N = 5,
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [N*N*W-1:0] mat_a,
    input  logic [N*N*W-1:0] mat_b,
    input  logic [W-1:0]     esc,
    output logic [N*N*W-1:0] mat_o,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int MW = N * N * W;
    localparam int CW = $clog2(N);
    localparam int AW = 2 * W + $clog2(N);
    localparam logic [CW-1:0] NM1 = CW'(N - 1);
    localparam logic signed [AW-1:0] EMAX = AW'((1 << (W - 1)) - 1);
    localparam logic signed [AW-1:0] EMIN = -EMAX - AW'(1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SCL = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_TRN = 3'b100;
    localparam logic [2:0] OP_HAD = 3'b101;

    typedef enum logic {IDLE, RUN} state_t;

    state_t              state;
    logic [2:0]          op_q;
    logic [MW-1:0]       a_q;
    logic [MW-1:0]       b_q;
    logic [W-1:0]        esc_q;
    logic [MW-1:0]       res;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]       r;
    logic [CW-1:0]       c;
    logic [CW-1:0]       k;

    logic signed [AW-1:0] a_rc, b_rc, a_cr, a_rk, b_kc, e_s, val;
    logic [MW-1:0]       res_next;
    logic [W-1:0]        elem;
    logic                elem_done;
    logic                elem_ovf;
    logic                last;
    int                  ri, ci, ki;

    always_comb begin
        ri   = int'(r);
        ci   = int'(c);
        ki   = int'(k);
        a_rc = AW'($signed(a_q[(ri*N+ci)*W +: W]));
        b_rc = AW'($signed(b_q[(ri*N+ci)*W +: W]));
        a_cr = AW'($signed(a_q[(ci*N+ri)*W +: W]));
        a_rk = AW'($signed(a_q[(ri*N+ki)*W +: W]));
        b_kc = AW'($signed(b_q[(ki*N+ci)*W +: W]));
        e_s  = AW'($signed(esc_q));

        case (op_q)
            OP_ADD:  val = a_rc + b_rc;
            OP_SUB:  val = a_rc - b_rc;
            OP_SCL:  val = e_s * a_rc;
            OP_MUL:  val = acc + a_rk * b_kc;
            OP_TRN:  val = a_cr;
            OP_HAD:  val = a_rc * b_rc;
            default: val = '0;
        endcase

        elem_ovf = (val > EMAX) || (val < EMIN);
`ifdef ULA_SAT_EN
        if (val > EMAX)
            elem = EMAX[W-1:0];
        else if (val < EMIN)
            elem = EMIN[W-1:0];
        else
            elem = val[W-1:0];
`else
        elem = val[W-1:0];
`endif

        // A matmul element is only final once its last MAC has been added.
        elem_done = (op_q != OP_MUL) || (k == NM1);
        last      = (op_q[2:1] == 2'b11) || (elem_done && (r == NM1) && (c == NM1));

        res_next = res;
        if (elem_done)
            res_next[(ri*N+ci)*W +: W] = elem;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            esc_q    <= '0;
            res      <= '0;
            acc      <= '0;
            r        <= '0;
            c        <= '0;
            k        <= '0;
            mat_o    <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_q     <= op;
                        a_q      <= mat_a;
                        b_q      <= mat_b;
                        esc_q    <= esc;
                        res      <= '0;
                        acc      <= '0;
                        r        <= '0;
                        c        <= '0;
                        k        <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    res      <= res_next;
                    overflow <= overflow | (elem_done & elem_ovf);
                    if (last) begin
                        mat_o <= res_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (op_q == OP_MUL && k != NM1) begin
                        k   <= k + CW'(1);
                        acc <= val;
                    end else begin
                        k   <= '0;
                        acc <= '0;
                        if (c == NM1) begin
                            c <= '0;
                            r <= r + CW'(1);
                        end else begin
                            c <= c + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
